// File: rtl/dmem_request_unit_if.sv
// Handshake bundle between the EX/MEM latch, the data-cache port, the hazard
// unit and dmem_request_unit. The slave side is the request unit itself; the
// master side is whatever drives the EX/MEM latch and the cache response.
interface dmem_request_unit_if;
  // EX/MEM latch side
  logic        ex_dREN;
  logic        ex_dWEN;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        ex_halt;
  // cache response
  logic        dhit;
  logic [31:0] dload;
  // cache request
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  // pipeline status
  logic        mem_busy;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        halt_out;
  logic        err;

  modport slave (
    input  ex_dREN, ex_dWEN, ex_addr, ex_wdata, ex_halt, dhit, dload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
           mem_busy, mem_done, mem_rdata, halt_out, err
  );

  modport master (
    output ex_dREN, ex_dWEN, ex_addr, ex_wdata, ex_halt, dhit, dload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
           mem_busy, mem_done, mem_rdata, halt_out, err
  );
endinterface

// File: rtl/dmem_request_unit.sv
// Data-memory request controller at the MEM end of the stall protocol.
// Takes one load/store from EX/MEM, holds it on the cache port until dhit,
// pulses mem_done for one cycle, then returns to IDLE. A halt parks the unit
// in HALTED until reset.
// Optional feature: define DMEM_REQ_TIMEOUT_EN to bound each access to
// WAIT_MAX REQ cycles; an expired access completes with err set sticky and
// mem_rdata cleared.
module dmem_request_unit #(
  parameter int unsigned WAIT_MAX = 1023
) (
  input logic               CLK,
  input logic               nRST,
  dmem_request_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, HALTED} state_t;

  // latched request presented to the cache
  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q;
  req_t        req_q;
  logic        done_q;
  logic        halt_q;
  logic [31:0] rdata_q;
  logic        new_req;
  logic        tmo;

  // a request in IDLE is only taken when no halt accompanies it
  assign new_req = (bus.ex_dREN | bus.ex_dWEN) & ~bus.ex_halt;

`ifdef DMEM_REQ_TIMEOUT_EN
  localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // expiry only when dhit is absent; a late hit still completes normally
  assign tmo = (state_q == REQ) && !bus.dhit && (cnt_q == CW'(WAIT_MAX - 1));

  // wait counter: held at zero outside REQ so it starts fresh on entry
  always_ff @(posedge CLK) begin
    if (!nRST)                 cnt_q <= '0;
    else if (state_q != REQ)   cnt_q <= '0;
    else if (!bus.dhit)        cnt_q <= cnt_q + 1'b1;
  end

  assign bus.err = err_q;
`else
  assign tmo     = 1'b0;
  assign bus.err = 1'b0;
`endif

  // main FSM with registered cache request, done pulse, load data and halt
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      req_q   <= '0;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
      rdata_q <= '0;
`ifdef DMEM_REQ_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.ex_halt) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end else if (new_req) begin
            // store wins when both strobes are set
            state_q     <= REQ;
            req_q.ren   <= bus.ex_dREN & ~bus.ex_dWEN;
            req_q.wen   <= bus.ex_dWEN;
            req_q.addr  <= bus.ex_addr;
            req_q.wdata <= bus.ex_wdata;
          end
        end
        REQ: begin
          if (bus.dhit) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            req_q.ren <= 1'b0;
            req_q.wen <= 1'b0;
            if (req_q.ren) rdata_q <= bus.dload;
          end else if (tmo) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            req_q.ren <= 1'b0;
            req_q.wen <= 1'b0;
            rdata_q   <= '0;
`ifdef DMEM_REQ_TIMEOUT_EN
            err_q     <= 1'b1;
`endif
          end
        end
        // EX/MEM advances at the end of DONE, so go straight back to IDLE
        DONE:    state_q <= IDLE;
        HALTED:  state_q <= HALTED;
        default: state_q <= IDLE;
      endcase
    end
  end

  // stall asserts combinationally in the cycle the request first appears
  assign bus.mem_busy  = (state_q == REQ) | ((state_q == IDLE) & new_req);
  assign bus.mem_done  = done_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.halt_out  = halt_q;
  assign bus.dmemREN   = req_q.ren;
  assign bus.dmemWEN   = req_q.wen;
  assign bus.dmemaddr  = req_q.addr;
  assign bus.dmemstore = req_q.wdata;

endmodule

// File: tb/tb_dmem_request_unit.sv
// Randomized bench for dmem_request_unit. Each access is modelled as a
// transaction: expected cache strobes, done timing, load data and error flag
// are derived from the request type and the cycle chosen for dhit.
module tb_dmem_request_unit;
  localparam int WM = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  dmem_request_unit_if bus();
  dmem_request_unit #(.WAIT_MAX(WM)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ex();
    bus.ex_dREN = 0; bus.ex_dWEN = 0; bus.ex_halt = 0;
    bus.ex_addr = '0; bus.ex_wdata = '0;
  endtask

  // one access: dhit arrives on REQ cycle delay+1 (1-based)
  task automatic access(input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int delay, input logic [31:0] ld);
    int j;
    bit hit, timed;
    @(posedge CLK); #1;
    bus.ex_dREN = r; bus.ex_dWEN = w; bus.ex_addr = a; bus.ex_wdata = d;
    bus.dhit = 0;
    @(negedge CLK);
    chk("busy_first", bus.mem_busy, 1);
    chk("done_first", bus.mem_done, 0);
    j = 0; timed = 0;
    forever begin
      j++;
      @(posedge CLK); #1;
      hit = (j == delay + 1);
      bus.dhit  = hit;
      bus.dload = hit ? ld : $urandom;
      @(negedge CLK);
      chk("req_ren",   bus.dmemREN, r & ~w);
      chk("req_wen",   bus.dmemWEN, w);
      chk("req_addr",  bus.dmemaddr, a);
      chk("req_store", bus.dmemstore, d);
      chk("req_busy",  bus.mem_busy, 1);
      chk("req_done",  bus.mem_done, 0);
`ifdef DMEM_REQ_TIMEOUT_EN
      if (!hit && j == WM) begin timed = 1; break; end
`endif
      if (hit) break;
      if (j > 200) begin chk("req_bound", j, 0); break; end
    end
    @(posedge CLK); #1;
    clear_ex();
    bus.dhit = $urandom_range(0, 1);
    bus.dload = $urandom;
    if (timed) begin exp_rdata = '0; exp_err = 1; end
    else if (r && !w) exp_rdata = ld;
    @(negedge CLK);
    chk("done_pulse", bus.mem_done, 1);
    chk("done_busy",  bus.mem_busy, 0);
    chk("done_ren",   bus.dmemREN, 0);
    chk("done_wen",   bus.dmemWEN, 0);
    chk("done_rdata", bus.mem_rdata, exp_rdata);
    chk("done_err",   bus.err, exp_err);
    @(posedge CLK); #1;
    bus.dhit = $urandom_range(0, 1);
    bus.dload = $urandom;
    @(negedge CLK);
    chk("idle_done",  bus.mem_done, 0);
    chk("idle_busy",  bus.mem_busy, 0);
    chk("idle_rdata", bus.mem_rdata, exp_rdata);
    bus.dhit = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ren"},   bus.dmemREN, 0);
    chk({tag, "_wen"},   bus.dmemWEN, 0);
    chk({tag, "_addr"},  bus.dmemaddr, 0);
    chk({tag, "_store"}, bus.dmemstore, 0);
    chk({tag, "_done"},  bus.mem_done, 0);
    chk({tag, "_rdata"}, bus.mem_rdata, 0);
    chk({tag, "_halt"},  bus.halt_out, 0);
    chk({tag, "_err"},   bus.err, 0);
    chk({tag, "_busy"},  bus.mem_busy, 0);
  endtask

  initial begin
    clear_ex();
    bus.dhit = 0; bus.dload = '0;
    nRST = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("rst");
    @(posedge CLK); #1 nRST = 1;

    // directed: load with dhit on the 4th REQ cycle, store with immediate hit, both strobes
    access(1, 0, 32'h100, 32'h0, 3, 32'hCAFEF00D);
    access(0, 1, 32'h204, 32'h12345678, 0, 32'hDEADBEEF);
    access(1, 1, 32'h308, 32'hA5A5A5A5, 1, 32'h11111111);
    // boundary: hit on the last allowed cycle, then a long wait (times out only when enabled)
    access(1, 0, 32'h40C, 32'h0, WM - 1, 32'h0BADF00D);
    access(1, 0, 32'h510, 32'h0, 100, 32'h77777777);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit r, w;
      int dl;
      r = $urandom_range(0, 1);
      w = $urandom_range(0, 1);
      if (!r && !w) r = 1;
      dl = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 4);
      access(r, w, $urandom, $urandom, dl, $urandom);
    end

    // reset two cycles into REQ aborts the access
    @(posedge CLK); #1;
    bus.ex_dREN = 1; bus.ex_addr = 32'h600;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 0; clear_ex();
    @(posedge CLK); #1 nRST = 1;
    exp_rdata = '0; exp_err = 0;
    @(negedge CLK);
    chk_all_zero("abort");
    repeat (3) begin
      @(negedge CLK);
      chk("abort_nodone", bus.mem_done, 0);
    end

    access(1, 0, 32'h700, 32'h0, 2, 32'h13572468);

    // halt beats a simultaneous load and blocks all later traffic
    @(posedge CLK); #1;
    bus.ex_halt = 1; bus.ex_dREN = 1; bus.ex_addr = 32'h800;
    @(negedge CLK);
    chk("halt_busy0", bus.mem_busy, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      bus.ex_halt = 0;
      bus.ex_dREN = $urandom_range(0, 1);
      bus.ex_dWEN = $urandom_range(0, 1);
      bus.dhit = $urandom_range(0, 1);
      @(negedge CLK);
      chk("halted_out",  bus.halt_out, 1);
      chk("halted_ren",  bus.dmemREN, 0);
      chk("halted_wen",  bus.dmemWEN, 0);
      chk("halted_busy", bus.mem_busy, 0);
      chk("halted_done", bus.mem_done, 0);
      chk("halted_rdata", bus.mem_rdata, exp_rdata);
    end
    @(posedge CLK); #1;
    nRST = 0; clear_ex(); bus.dhit = 0;
    @(posedge CLK); #1 nRST = 1;
    @(negedge CLK);
    chk("post_halt_rst", bus.halt_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
